fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write requesters, 2..8.
REQ-002 Parameter BURST, default 4: maximum consecutive grants to one requester, 1..15.
REQ-003 Parameter DW, default 8: data width, matching the FIFO din width.
REQ-004 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1: synchronous, active-high reset.
REQ-006 Port req  input  NUM_REQ: per-requester write request; held until granted.
REQ-007 Port req_data  input  NUM_REQ*DW: per-requester data; slice i = bits [i*DW +: DW].
REQ-008 Port gnt  output  NUM_REQ: one-hot acknowledge; data slice i is consumed at the edge where gnt[i]=1.
REQ-009 Port fifo_full  input  1: FIFO full flag.
REQ-010 Port fifo_wr  output  1: FIFO write strobe.
REQ-011 Port fifo_din  output  DW: FIFO write data.

Function
REQ-012 gnt, fifo_wr and fifo_din SHALL be combinational from req, fifo_full and registered state, with zero-cycle latency from req to gnt.
REQ-013 gnt SHALL be all-zero when fifo_full=1, when rst=1, or when req=0.
REQ-014 At most one gnt bit SHALL be high in any cycle.
REQ-015 fifo_wr SHALL equal OR(gnt); fifo_din SHALL equal the granted slice, else 0.
REQ-016 Registered state: owner (index of last granted requester), owner_valid, burst_cnt (4 bits).
REQ-017 Hold rule: if owner_valid, req[owner]=1 and burst_cnt<BURST-1, gnt SHALL select owner.
REQ-018 Rotate rule: otherwise, gnt SHALL select the first requesting index scanning owner+1, owner+2, ... modulo NUM_REQ.
REQ-019 On a grant to the same owner, burst_cnt SHALL increment; on a grant to a new index, owner SHALL load that index, burst_cnt SHALL load 0, and owner_valid SHALL be set.
REQ-020 On a cycle with no grant caused by req=0, owner_valid SHALL clear and burst_cnt SHALL clear; owner SHALL hold.
REQ-021 On a cycle with no grant caused by fifo_full=1, owner, owner_valid and burst_cnt SHALL all hold (stall without losing the burst position).
REQ-022 The owner index SHALL wrap from NUM_REQ-1 to 0.
REQ-023 With BURST=1, the arbiter SHALL be pure round-robin, one grant per requester in turn.
REQ-024 Fairness: with all requesters continuously active and the FIFO never full, each requester SHALL receive exactly BURST grants per NUM_REQ*BURST cycles.

Reset
REQ-025 rst=1 SHALL force owner=NUM_REQ-1, owner_valid=0 and burst_cnt=0 at the next edge, so that requester 0 has first priority after reset.
REQ-026 Reset asserted mid-burst SHALL suppress gnt in that same cycle; no FIFO write SHALL occur during reset.

Configuration
REQ-027 Macro FIFO_WR_ARB_STATS_EN: when defined, the block SHALL add output grant_cnt (NUM_REQ*16 bits; per-requester saturating grant counters) and output stall_cnt (16 bits; saturating count of cycles with req!=0 and fifo_full=1), all cleared by rst.
REQ-028 Without FIFO_WR_ARB_STATS_EN, those ports and counters SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-029 Package fifo_arb_pkg SHALL hold the DW, NUM_REQ and BURST defaults, the counter width constant (16), and the owner-index typedef.
REQ-030 Sub-module rr_pick SHALL implement the combinational rotate-priority search (inputs: req, start index; outputs: found, index).

Verification
REQ-031 Reset, then req=4'b1111 with fifo_full=0 held for 16 cycles, BURST=4 -> grants in the order 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3.
REQ-032 req=4'b0101 with BURST=1 -> gnt alternates 0001, 0100; fifo_din matches the granted slice every cycle.
REQ-033 Requester 2 is mid-burst at burst_cnt=1 when fifo_full rises for 3 cycles -> gnt=0 and fifo_wr=0 for those 3 cycles, then 2 more grants to requester 2, then rotation to 3.
REQ-034 req[1] drops after 2 grants, with only req[3] still active -> the next grant goes to 3, with burst_cnt=0.
REQ-035 rst is pulsed during requester 3's burst -> gnt=0 in the reset cycle; the first grant after reset goes to the lowest active index.
REQ-036 With FIFO_WR_ARB_STATS_EN defined: 10 grants to requester 0 and 5 full-stall cycles -> grant_cnt[0]=10 and stall_cnt=5; counters saturate at 16'hFFFF.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared constants and types for the FIFO write arbiter.
// Optional statistics counters are enabled with the FIFO_WR_ARB_STATS_EN macro.
package fifo_arb_pkg;

  localparam int unsigned DefDw     = 8;
  localparam int unsigned DefNumReq = 4;
  localparam int unsigned DefBurst  = 4;
  localparam int unsigned MaxReq    = 8;
  localparam int unsigned CntW      = 16;
  localparam int unsigned OwnerW    = $clog2(MaxReq);
  localparam int unsigned BurstW    = 4;

  typedef logic [OwnerW-1:0] owner_idx_t;
  typedef logic [BurstW-1:0] burst_cnt_t;

  // Saturating increment for the statistics counters.
  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: finds the first set request bit starting at start_i and
// wrapping modulo N. Purely combinational.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N = DefNumReq
) (
  input  logic [N-1:0] req_i,
  input  owner_idx_t   start_i,
  output logic         found_o,
  output owner_idx_t   idx_o
);

  logic [2*N-1:0]  req_dbl;
  logic [N-1:0]    req_rot;
  logic [OwnerW:0] sum;

  // Rotate so that start_i lands at bit 0, then take the lowest set bit.
  always_comb begin
    req_dbl = {req_i, req_i};
    req_rot = N'(req_dbl >> start_i);
    found_o = |req_i;
    idx_o   = '0;
    sum     = '0;
    // Descending scan so the smallest offset from start_i wins.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        sum = {1'b0, start_i} + (OwnerW + 1)'(i);
        if (sum >= (OwnerW + 1)'(N)) begin
          sum = sum - (OwnerW + 1)'(N);
        end
        idx_o = sum[OwnerW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Burst-limited round-robin arbiter feeding one FIFO write port from NUM_REQ requesters.
// Grants are combinational from req/fifo_full and the registered owner state.
// Define FIFO_WR_ARB_STATS_EN to add per-requester grant counters and a stall counter.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned BURST   = DefBurst,
  parameter int unsigned DW      = DefDw
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    gnt,
  input  logic                  fifo_full,
  output logic                  fifo_wr,
  output logic [DW-1:0]         fifo_din
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CntW-1:0] grant_cnt,
  output logic [CntW-1:0]         stall_cnt
`endif
);

  localparam owner_idx_t LastIdx = owner_idx_t'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] OneHot0 = {{(NUM_REQ - 1){1'b0}}, 1'b1};

  owner_idx_t owner_q, owner_d;
  logic       owner_valid_q, owner_valid_d;
  burst_cnt_t burst_cnt_q, burst_cnt_d;

  owner_idx_t start_idx, pick_idx, gnt_idx;
  logic       pick_found, owner_req, hold, grant_en;

  assign start_idx = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .req_i   (req),
    .start_i (start_idx),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Grant selection: keep the current owner while its burst has room, else rotate.
  always_comb begin
    owner_req = |(req & (OneHot0 << owner_q));
    hold      = owner_valid_q && owner_req && (({1'b0, burst_cnt_q} + 5'd1) < 5'(BURST));
    gnt_idx   = hold ? owner_q : pick_idx;
    grant_en  = !rst && !fifo_full && pick_found;
    gnt       = grant_en ? (OneHot0 << gnt_idx) : '0;
    fifo_wr   = grant_en;
    fifo_din  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt[i]) begin
        fifo_din = req_data[i*DW +: DW];
      end
    end
  end

  // Owner/burst next state. A full FIFO freezes everything so the burst resumes intact.
  always_comb begin
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    burst_cnt_d   = burst_cnt_q;
    if (grant_en) begin
      if (owner_valid_q && (gnt_idx == owner_q)) begin
        // Re-grant after an exhausted burst (nobody else asking) keeps the count saturated
        // at BURST-1 so other requesters regain priority as soon as they assert.
        if (hold) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end else begin
        owner_d     = gnt_idx;
        burst_cnt_d = '0;
      end
      owner_valid_d = 1'b1;
    end else if (!fifo_full && (req == '0)) begin
      owner_valid_d = 1'b0;
      burst_cnt_d   = '0;
    end
  end

  // Owner state register; reset points the owner at the last index so index 0 goes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q       <= LastIdx;
      owner_valid_q <= 1'b0;
      burst_cnt_q   <= '0;
    end else begin
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      burst_cnt_q   <= burst_cnt_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [CntW-1:0] grant_cnt_q [NUM_REQ];
  logic [CntW-1:0] grant_cnt_d [NUM_REQ];
  logic [CntW-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating statistics next state.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      grant_cnt_d[i] = gnt[i] ? sat_inc(grant_cnt_q[i]) : grant_cnt_q[i];
    end
    stall_cnt_d = (fifo_full && (req != '0)) ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        grant_cnt_q[i] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        grant_cnt_q[i] <= grant_cnt_d[i];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      grant_cnt[i*CntW +: CntW] = grant_cnt_q[i];
    end
    stall_cnt = stall_cnt_q;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed vector table, a BURST=1 instance, a fairness window and
// randomized traffic against a behavioural model. Honors FIFO_WR_ARB_STATS_EN if defined.
module tb_fifo_wr_arb;

  localparam int N = 4;
  localparam int B = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, fifo_full, fifo_wr;
  logic [N-1:0]   req, gnt;
  logic [N*W-1:0] req_data;
  logic [W-1:0]   fifo_din;

  logic           rst_b, wr_b;
  logic [N-1:0]   req_b, gnt_b;
  logic [N*W-1:0] data_b;
  logic [W-1:0]   din_b;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt, grant_cnt_b;
  logic [15:0]     stall_cnt, stall_cnt_b;
`endif

  fifo_wr_arb #(.NUM_REQ(N), .BURST(B), .DW(W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_din  (fifo_din)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  fifo_wr_arb #(.NUM_REQ(N), .BURST(1), .DW(W)) u_dut_b1 (
    .clk       (clk),
    .rst       (rst_b),
    .req       (req_b),
    .req_data  (data_b),
    .gnt       (gnt_b),
    .fifo_full (1'b0),
    .fifo_wr   (wr_b),
    .fifo_din  (din_b)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt_b),
    .stall_cnt (stall_cnt_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model of the arbitration rules.
  int m_owner;
  bit m_valid;
  int m_cnt;
  int m_gcnt [N];
  int m_stall;

  typedef struct {
    logic         rs;
    logic [N-1:0] r;
    logic         f;
    logic [N-1:0] g;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit has_req(input logic [N-1:0] r, input int c);
    logic [N-1:0] m;
    m = 1;
    m = m << c;
    return |(r & m);
  endfunction

  function automatic int ref_pick(input logic [N-1:0] r, input logic f, input logic rs);
    if (rs || f || (r == '0)) return -1;
    if (m_valid && has_req(r, m_owner) && (m_cnt < B - 1)) return m_owner;
    for (int k = 1; k <= N; k++) begin
      if (has_req(r, (m_owner + k) % N)) return (m_owner + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] g;
    g = 1;
    return (idx < 0) ? '0 : (g << idx);
  endfunction

  task automatic model_update(input logic [N-1:0] r, input logic f, input logic rs,
                              input int pick);
    if (rs) begin
      m_owner = N - 1;
      m_valid = 0;
      m_cnt   = 0;
      for (int i = 0; i < N; i++) m_gcnt[i] = 0;
      m_stall = 0;
    end else if (f) begin
      if (r != '0 && m_stall < 65535) m_stall++;
    end else if (r == '0) begin
      m_valid = 0;
      m_cnt   = 0;
    end else begin
      if (m_valid && pick == m_owner) begin
        m_cnt = (m_cnt + 1 > B - 1) ? B - 1 : m_cnt + 1;
      end else begin
        m_owner = pick;
        m_cnt   = 0;
      end
      m_valid = 1;
      if (m_gcnt[pick] < 65535) m_gcnt[pick]++;
    end
  endtask

  // Drive one cycle, compare outputs mid-cycle, then advance the model past the edge.
  task automatic step(input logic rs, input logic [N-1:0] r, input logic f,
                      input logic [N-1:0] exp_g, input string tag);
    logic [W-1:0] exp_din;
    int pick;
    rst       = rs;
    req       = r;
    fifo_full = f;
    req_data  = $urandom;
    #1;
    exp_din = '0;
    for (int i = 0; i < N; i++) if (exp_g[i]) exp_din = req_data[i*W +: W];
    check({tag, " gnt"}, 32'(gnt), 32'(exp_g));
    check({tag, " fifo_wr"}, 32'(fifo_wr), 32'(|exp_g));
    check({tag, " fifo_din"}, 32'(fifo_din), 32'(exp_din));
    pick = ref_pick(r, f, rs);
    model_update(r, f, rs, pick);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rs, input logic [N-1:0] r, input logic f,
                     input logic [N-1:0] g);
    vec_t v;
    v.rs = rs; v.r = r; v.f = f; v.g = g;
    tbl.push_back(v);
  endtask

  initial begin
    int fair [N];
    logic [N-1:0] r, g;
    logic f, rs;
    logic [W-1:0] exp_din;

    rst = 1; req = '0; fifo_full = 0; req_data = '0;
    rst_b = 1; req_b = '0; data_b = '0;
    m_owner = 0; m_valid = 0; m_cnt = 0; m_stall = 0;
    for (int i = 0; i < N; i++) m_gcnt[i] = 0;
    @(posedge clk);
    model_update('0, 1'b0, 1'b1, -1);
    #1;
    rst_b = 0;

    // Reset cycle, full round of bursts, stall mid-burst, early drop, reset mid-burst.
    add(1, 4'b1111, 0, 4'b0000);
    for (int k = 0; k < 16; k++) add(0, 4'b1111, 0, onehot(k / 4));
    add(0, 4'b0100, 0, 4'b0100);
    add(0, 4'b0100, 0, 4'b0100);
    for (int k = 0; k < 3; k++) add(0, 4'b1100, 1, 4'b0000);
    add(0, 4'b1100, 0, 4'b0100);
    add(0, 4'b1100, 0, 4'b0100);
    add(0, 4'b1100, 0, 4'b1000);
    add(0, 4'b0010, 0, 4'b0010);
    add(0, 4'b1010, 0, 4'b0010);
    add(0, 4'b1000, 0, 4'b1000);
    for (int k = 0; k < 3; k++) add(0, 4'b1001, 0, 4'b1000);
    add(0, 4'b1001, 0, 4'b0001);
    add(0, 4'b1000, 0, 4'b1000);
    add(0, 4'b1000, 0, 4'b1000);
    add(1, 4'b1000, 0, 4'b0000);
    add(0, 4'b1010, 0, 4'b0010);
    add(0, 4'b0000, 0, 4'b0000);
    add(0, 4'b0010, 0, 4'b0010);
    add(0, 4'b0011, 0, 4'b0010);
    foreach (tbl[i]) step(tbl[i].rs, tbl[i].r, tbl[i].f, tbl[i].g, $sformatf("vec%0d", i));

    // BURST=1 instance: strict alternation between requesters 0 and 2.
    for (int k = 0; k < 6; k++) begin
      req_b  = 4'b0101;
      data_b = $urandom;
      #1;
      g = (k % 2 == 1) ? 4'b0100 : 4'b0001;
      exp_din = (k % 2 == 1) ? data_b[2*W +: W] : data_b[0 +: W];
      check($sformatf("b1 gnt %0d", k), 32'(gnt_b), 32'(g));
      check($sformatf("b1 din %0d", k), 32'(din_b), 32'(exp_din));
      @(posedge clk);
      #1;
    end
    req_b = '0;

    // Fairness window: all active, never full.
    step(1, 4'b1111, 0, 4'b0000, "fair rst");
    for (int i = 0; i < N; i++) fair[i] = 0;
    for (int k = 0; k < 2 * N * B; k++) begin
      g = onehot(ref_pick(4'b1111, 1'b0, 1'b0));
      step(0, 4'b1111, 0, g, "fair");
      for (int i = 0; i < N; i++) if (gnt_q_hist(i)) fair[i]++;
    end
    for (int i = 0; i < N; i++) check($sformatf("fair count %0d", i), 32'(fair[i]), 32'(2 * B));

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      r  = 4'($urandom_range(0, 15));
      f  = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 31) == 0);
      g  = onehot(ref_pick(r, f, rs));
      step(rs, r, f, g, "rand");
    end

`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      check($sformatf("grant_cnt %0d", i), 32'(grant_cnt[i*16 +: 16]), 32'(m_gcnt[i]));
    end
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("stall_cnt_b", 32'(stall_cnt_b), 32'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Grant seen in the cycle just before the last edge (captured for the fairness tally).
  logic [N-1:0] gnt_last;
  always @(posedge clk) gnt_last <= gnt;

  function automatic bit gnt_q_hist(input int i);
    return has_req(gnt_last, i);
  endfunction

endmodule
